// File: rtl/iic_slave_regs.sv
// I2C slave exposing a small byte register file through a pointer byte, with write strobes.
// Optional macro IIC_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda.
module iic_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // stage p0/p1: two-flop synchronizers, reset to the idle-bus level
  logic scl_p0, scl_p1, sda_p0, sda_p1;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
    end
  end

  logic scl_s, sda_s;
`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  // stage p2: majority over three consecutive samples rejects single-cycle pulses
  logic scl_h0, scl_h1, sda_h0, sda_h1, scl_p2, sda_p2;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      scl_h0 <= 1'b1;
      scl_h1 <= 1'b1;
      sda_h0 <= 1'b1;
      sda_h1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_h0 <= scl_p1;
      scl_h1 <= scl_h0;
      sda_h0 <= sda_p1;
      sda_h1 <= sda_h0;
      scl_p2 <= maj3(scl_p1, scl_h0, scl_h1);
      sda_p2 <= maj3(sda_p1, sda_h0, sda_h1);
    end
  end
  assign scl_s = scl_p2;
  assign sda_s = sda_p2;
`else
  assign scl_s = scl_p1;
  assign sda_s = sda_p1;
`endif

  logic scl_q, sda_q;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & sda_q & ~sda_s;
  assign stop     = scl_s & ~sda_q & sda_s;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [NUM_REGS];

  logic [7:0]    rx_byte;
  logic [AW-1:0] ptr_inc;
  assign rx_byte = {shreg[6:0], sda_s};
  assign ptr_inc = ptr + AW'(1);

  // protocol FSM; in the ACK states sda_oe doubles as the "ACK already driven" phase flag
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ptr       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              case (state)
                ADDR: if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state <= ADDR_ACK;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= IDLE;
                end
                PTR: begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= PTR_ACK;
                end
                default: begin
                  regs[ptr] <= rx_byte;
                  wr_strobe <= 1'b1;
                  wr_addr   <= 4'(ptr);
                  wr_data   <= rx_byte;
                  ptr       <= ptr_inc;
                  state     <= WDATA_ACK;
                end
              endcase
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              state  <= RDATA;
              shreg  <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end else begin
              sda_oe <= 1'b0;
              state  <= (state == ADDR_ACK) ? PTR : WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RDATA_ACK;
              end else if (bit_cnt == 4'd0) begin
                sda_oe <= ~shreg[7];
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          RDATA_ACK: if (scl_rise) begin
            if (!sda_s) begin
              ptr     <= ptr_inc;
              shreg   <= regs[ptr_inc];
              bit_cnt <= '0;
              state   <= RDATA;
            end else begin
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench for iic_slave_regs: an open-drain I2C master model driven from tasks.
module tb_iic_slave_regs;
  localparam int Q = 6;
`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  localparam int   LAT        = 5;
  localparam logic GLITCH_ACK = 1'b1;
`else
  localparam int   LAT        = 3;
  localparam logic GLITCH_ACK = 1'b0;
`endif

  logic       pclk, presetn, scl, sda_m, sda_in, sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int         total = 0;
  int         bad   = 0;
  logic [11:0] stq[$];
  logic       sda_low_seen = 1'b0;
  logic       busy_seen    = 1'b0;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic [3:0] exp_addr;
  } vec_t;
  vec_t vecs[4];

  assign sda_in = sda_m & ~sda_oe;

  iic_slave_regs #(.SLAVE_ADDR(7'h50), .NUM_REGS(16)) dut (
    .pclk(pclk), .presetn(presetn), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (wr_strobe) stq.push_back({wr_addr, wr_data});
    if (sda_oe) sda_low_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_strobe(input string name, input logic [11:0] exp);
    logic [11:0] got;
    if (stq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no write want %0h", name, exp);
    end else begin
      got = stq.pop_front();
      check(name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic clock_bit(input logic d, output logic got);
    sda_m = d; tick(Q);
    scl = 1'b1; tick(Q);
    got = sda_in; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], g);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, g);
      b[i] = g;
    end
    clock_bit(ack, g);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  // pointer write, repeated START, then read n_ack bytes with ACK followed by one NACK
  task automatic read_at(input logic [7:0] p, input logic two, output logic [7:0] r0,
                         output logic [7:0] r1, output logic acks);
    logic a0, a1, a2;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(p, a1);
    bus_start();
    send_byte(8'hA1, a2);
    r1 = 8'h00;
    if (two) begin
      recv_byte(1'b0, r0);
      recv_byte(1'b1, r1);
    end else begin
      recv_byte(1'b1, r0);
    end
    bus_stop();
    acks = a0 | a1 | a2;
  endtask

  initial begin
    logic a0, a1, a2, a3, g, acks;
    logic [7:0] r0, r1, d;
    vecs[0] = '{ptr: 8'h21, data: 8'h81, exp_addr: 4'd1};
    vecs[1] = '{ptr: 8'h3A, data: 8'h7E, exp_addr: 4'd10};
    vecs[2] = '{ptr: 8'hF7, data: 8'hFF, exp_addr: 4'd7};
    vecs[3] = '{ptr: 8'h06, data: 8'h5B, exp_addr: 4'd6};

    presetn = 1'b0; scl = 1'b1; sda_m = 1'b1;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    presetn = 1'b1;
    tick(4);

    // two-byte write from pointer 3, busy drop timing at STOP
    bus_start();
    send_byte(8'hA0, a0); send_byte(8'h03, a1); send_byte(8'hA5, a2); send_byte(8'h3C, a3);
    check("w_ack_addr", a0, 0); check("w_ack_ptr", a1, 0);
    check("w_ack_d0", a2, 0);   check("w_ack_d1", a3, 0);
    check("busy_in_xfer", busy, 1);
    sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1;
    tick(LAT - 1);
    check("busy_before_stop_lat", busy, 1);
    tick(1);
    check("busy_after_stop", busy, 0);
    tick(Q);
    check("w_count", stq.size(), 2);
    check_strobe("w_strobe0", {4'd3, 8'hA5});
    check_strobe("w_strobe1", {4'd4, 8'h3C});

    // read back through repeated START, then confirm the slave let go after NACK
    stq.delete();
    bus_start();
    send_byte(8'hA0, a0); send_byte(8'h03, a1);
    bus_start();
    send_byte(8'hA1, a2);
    recv_byte(1'b0, r0); recv_byte(1'b1, r1);
    check("r_acks", {a0, a1, a2}, 3'b000);
    check("r_byte0", r0, 8'hA5);
    check("r_byte1", r1, 8'h3C);
    clock_bit(1'b1, g);
    check("r_released_after_nack", g, 1);
    bus_stop();
    check("r_no_writes", stq.size(), 0);

    // foreign address
    stq.delete(); sda_low_seen = 1'b0; busy_seen = 1'b0;
    bus_start();
    send_byte(8'hA2, a0); send_byte(8'h00, a1);
    bus_stop();
    check("na_nack", a0, 1);
    check("na_sda_never_low", sda_low_seen, 0);
    check("na_busy_never", busy_seen, 0);
    check("na_no_writes", stq.size(), 0);

    // pointer wrap on write and on read
    stq.delete();
    bus_start();
    send_byte(8'hA0, a0); send_byte(8'h0F, a1); send_byte(8'h11, a2); send_byte(8'h22, a3);
    bus_stop();
    check_strobe("wrap_w0", {4'd15, 8'h11});
    check_strobe("wrap_w1", {4'd0, 8'h22});
    read_at(8'h0F, 1'b1, r0, r1, acks);
    check("wrap_r_acks", acks, 0);
    check("wrap_r0", r0, 8'h11);
    check("wrap_r1", r1, 8'h22);

    for (int i = 0; i < 4; i++) begin
      stq.delete();
      bus_start();
      send_byte(8'hA0, a0); send_byte(vecs[i].ptr, a1); send_byte(vecs[i].data, a2);
      bus_stop();
      check($sformatf("vec%0d_acks", i), {a0, a1, a2}, 3'b000);
      check_strobe($sformatf("vec%0d_strobe", i), {vecs[i].exp_addr, vecs[i].data});
      read_at(vecs[i].ptr, 1'b0, r0, r1, acks);
      check($sformatf("vec%0d_read", i), r0, vecs[i].data);
    end

    // reset pulse in the middle of a data byte
    stq.delete();
    d = 8'h5A;
    bus_start();
    send_byte(8'hA0, a0); send_byte(8'h03, a1);
    for (int i = 7; i >= 5; i--) clock_bit(d[i], g);
    sda_m = d[4]; tick(Q); scl = 1'b1; tick(Q);
    check("mid_busy", busy, 1);
    presetn = 1'b0;
    #1;
    check("mid_rst_sda_oe", sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    tick(2); presetn = 1'b1; tick(Q - 2);
    scl = 1'b0; tick(Q);
    sda_low_seen = 1'b0; busy_seen = 1'b0;
    for (int i = 3; i >= 0; i--) clock_bit(d[i], g);
    clock_bit(1'b1, a2);
    send_byte(8'h77, a3);
    bus_stop();
    check("mid_nack_rest", a2, 1);
    check("mid_nack_next", a3, 1);
    check("mid_no_writes", stq.size(), 0);
    check("mid_sda_never_low", sda_low_seen, 0);
    check("mid_busy_never", busy_seen, 0);
    bus_start();
    send_byte(8'hA1, a0); recv_byte(1'b1, r0);
    bus_stop();
    check("mid_ptr0_ack", a0, 0);
    check("mid_reg0_cleared", r0, 8'h00);
    read_at(8'h03, 1'b1, r0, r1, acks);
    check("mid_reg3_cleared", r0, 8'h00);
    check("mid_reg4_cleared", r1, 8'h00);

    // one-cycle SDA low while SCL high, then SCL falls as SDA returns high
    tick(Q);
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1; scl = 1'b0; tick(Q);
    send_byte(8'hA0, a0);
    check("glitch_start_ack", a0, GLITCH_ACK);
    bus_stop();
    tick(Q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
